// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline control slice.
package pipeline_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_BUSY = 2'd1,
        ST_HALT = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the instruction in ID and a load in EX.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    input  logic                  i_id_uses_rs,
    input  logic                  i_id_uses_rt,
    input  logic                  i_ex_is_load,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    output logic                  o_load_use
);

    logic w_rs_hit;
    logic w_rt_hit;

    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    always_comb begin
        w_rs_hit   = i_id_uses_rs && (i_id_rs == i_ex_rd);
        w_rt_hit   = i_id_uses_rt && (i_id_rt == i_ex_rd);
        o_load_use = i_ex_is_load && (i_ex_rd != '0) && (w_rs_hit || w_rt_hit);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: load-use interlock, branch flush,
// multi-cycle multiply/divide freeze and halt/resume handling.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  branch_taken,
    input  logic                  md_start,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic                  pc_we,
    output logic                  ifid_we,
    output logic                  ifid_flush,
    output logic                  idex_we,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  md_busy,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  stall_cycles
);

    // The md_start cycle is the first freeze cycle, so BUSY lasts MD_LATENCY-1.
    localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [3:0]           r_md_cnt;
    logic [3:0]           w_md_cnt_next;
    logic [CNT_WIDTH-1:0] r_stall;
    logic                 w_load_use;

    hazard_detect u_hazard_detect (
        .i_id_rs      (id_rs),
        .i_id_rt      (id_rt),
        .i_id_uses_rs (id_uses_rs),
        .i_id_uses_rt (id_uses_rt),
        .i_ex_is_load (ex_is_load),
        .i_ex_rd      (ex_rd),
        .o_load_use   (w_load_use)
    );

    // State, latency counter and stall statistic registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_md_cnt <= '0;
            r_stall  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_md_cnt <= w_md_cnt_next;
            if (!pc_we && (r_stall != '1)) begin
                r_stall <= r_stall + CNT_WIDTH'(1);
            end
        end
    end

    // Next-state and pipeline enable/flush decode; everything is forced low during reset.
    always_comb begin
        w_state_next  = r_state;
        w_md_cnt_next = r_md_cnt;
        pc_we         = 1'b0;
        ifid_we       = 1'b0;
        ifid_flush    = 1'b0;
        idex_we       = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        if (!rst) begin
            unique case (r_state)
                ST_RUN: begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                    idex_we = 1'b1;
                    if (halt_req) begin
                        pc_we        = 1'b0;
                        ifid_we      = 1'b0;
                        idex_we      = 1'b0;
                        exmem_flush  = 1'b1;
                        w_state_next = ST_HALT;
                    end else if (md_start) begin
                        pc_we         = 1'b0;
                        ifid_we       = 1'b0;
                        idex_we       = 1'b0;
                        exmem_flush   = 1'b1;
                        w_state_next  = ST_BUSY;
                        w_md_cnt_next = MD_LOAD;
                    end else if (branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (w_load_use) begin
                        pc_we      = 1'b0;
                        ifid_we    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                ST_BUSY: begin
                    exmem_flush = 1'b1;
                    if (r_md_cnt == 4'd1) begin
                        w_state_next = ST_RUN;
                    end else begin
                        w_md_cnt_next = r_md_cnt - 4'd1;
                    end
                end
                ST_HALT: begin
                    exmem_flush = 1'b1;
                    if (resume) begin
                        w_state_next = ST_RUN;
                    end
                end
                default: begin
                    w_state_next = ST_RUN;
                end
            endcase
        end
    end

    // Status flags track the state register but read as idle while reset is held.
    always_comb begin
        md_busy      = !rst && (r_state == ST_BUSY);
        halted       = !rst && (r_state == ST_HALT);
        stall_cycles = r_stall;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
module tb_pipeline_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rs, id_uses_rt, ex_is_load;
    logic       branch_taken, md_start, halt_req, resume;

    logic        pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush, md_busy, halted;
    logic [31:0] stall_cycles;
    logic        s_pc_we, s_ifid_we, s_ifid_flush, s_idex_we, s_idex_flush, s_exmem_flush;
    logic        s_md_busy, s_halted;
    logic [1:0]  s_stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_stall;

    pipeline_ctrl #(.MD_LATENCY(4), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .md_start(md_start), .halt_req(halt_req), .resume(resume),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_we(idex_we), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .md_busy(md_busy), .halted(halted), .stall_cycles(stall_cycles)
    );

    // Narrow counter instance, used to observe saturation.
    pipeline_ctrl #(.MD_LATENCY(4), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .md_start(md_start), .halt_req(halt_req), .resume(resume),
        .pc_we(s_pc_we), .ifid_we(s_ifid_we), .ifid_flush(s_ifid_flush),
        .idex_we(s_idex_we), .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush),
        .md_busy(s_md_busy), .halted(s_halted), .stall_cycles(s_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle order: pc_we ifid_we ifid_flush idex_we idex_flush exmem_flush md_busy halted
    logic [7:0] outs;
    assign outs = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush, md_busy, halted};

    localparam logic [7:0] O_RUN    = 8'b1101_0000;
    localparam logic [7:0] O_LU     = 8'b0001_1000;
    localparam logic [7:0] O_BR     = 8'b1111_1000;
    localparam logic [7:0] O_FREEZE = 8'b0000_0100;
    localparam logic [7:0] O_BUSY   = 8'b0000_0110;
    localparam logic [7:0] O_HALT   = 8'b0000_0101;
    localparam logic [7:0] O_RST    = 8'b0000_0000;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       ld;
        logic [4:0] rd;
        logic       br;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Inputs are already applied; check combinational outputs mid-cycle, then cross the edge.
    task automatic run_cycle(input logic [7:0] exp, input string nm);
        @(negedge clk);
        chk(nm, {24'd0, outs}, {24'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        id_rs = '0; id_rt = '0; ex_rd = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_is_load = 1'b0;
        branch_taken = 1'b0; md_start = 1'b0; halt_req = 1'b0; resume = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        clear_inputs();
        run_cycle(O_RST, "rst_outs0");
        run_cycle(O_RST, "rst_outs1");
        chk("rst_stall", stall_cycles, 32'd0);
        chk("rst_stall_sat", {30'd0, s_stall_cycles}, 32'd0);
        rst = 1'b0;
        exp_stall = 0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        exp_stall = 0;

        vecs[0] = '{"idle",        5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, O_RUN};
        vecs[1] = '{"lu_rs",       5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, O_LU};
        vecs[2] = '{"lu_rd0",      5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, O_RUN};
        vecs[3] = '{"lu_no_use",   5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, O_RUN};
        vecs[4] = '{"lu_rt",       5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, O_LU};
        vecs[5] = '{"lu_rt_unused",5'd1, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, O_RUN};
        vecs[6] = '{"no_load",     5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0, O_RUN};
        vecs[7] = '{"lu_plus_br",  5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, O_BR};
        vecs[8] = '{"branch",      5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, O_BR};
        vecs[9] = '{"rs_mismatch", 5'd4, 5'd3, 1'b1, 1'b1, 1'b1, 5'd31, 1'b0, O_RUN};

        @(posedge clk);
        #1;
        do_reset();
        run_cycle(O_RUN, "post_reset_run");

        // Single-cycle RUN-state vectors.
        for (int i = 0; i < 10; i++) begin
            id_rs = vecs[i].rs; id_rt = vecs[i].rt;
            id_uses_rs = vecs[i].urs; id_uses_rt = vecs[i].urt;
            ex_is_load = vecs[i].ld; ex_rd = vecs[i].rd;
            branch_taken = vecs[i].br;
            run_cycle(vecs[i].exp, vecs[i].name);
            if (vecs[i].exp[7] == 1'b0) exp_stall++;
            chk({vecs[i].name, "_stall"}, stall_cycles, 32'(exp_stall));
        end
        clear_inputs();
        run_cycle(O_RUN, "lu_one_cycle_only");
        chk("vec_stall_total", stall_cycles, 32'd2);

        // Multiply/divide freeze; other inputs during BUSY must be ignored.
        do_reset();
        md_start = 1'b1;
        run_cycle(O_FREEZE, "md_start");
        md_start = 1'b0;
        halt_req = 1'b1; branch_taken = 1'b1;
        ex_is_load = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1;
        for (int i = 0; i < 3; i++) run_cycle(O_BUSY, "md_busy");
        clear_inputs();
        run_cycle(O_RUN, "md_done");
        chk("md_stall", stall_cycles, 32'd4);
        chk("md_stall_sat", {30'd0, s_stall_cycles}, 32'd3);

        // Halt for 10 cycles, resume on the 10th; md_start/halt_req ignored while halted.
        do_reset();
        halt_req = 1'b1;
        run_cycle(O_FREEZE, "halt_req");
        halt_req = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            md_start = (i == 3);
            halt_req = (i == 3);
            resume   = (i == 10);
            run_cycle(O_HALT, "halted");
        end
        clear_inputs();
        run_cycle(O_RUN, "resumed");
        chk("halt_stall", stall_cycles, 32'd11);
        chk("halt_stall_sat", {30'd0, s_stall_cycles}, 32'd3);

        // Reset asserted in the second BUSY cycle aborts the operation.
        do_reset();
        md_start = 1'b1;
        run_cycle(O_FREEZE, "abort_md_start");
        md_start = 1'b0;
        run_cycle(O_BUSY, "abort_busy1");
        rst = 1'b1;
        run_cycle(O_RST, "abort_in_rst");
        chk("abort_stall_rst", stall_cycles, 32'd0);
        rst = 1'b0;
        run_cycle(O_RUN, "abort_run0");
        run_cycle(O_RUN, "abort_run1");
        chk("abort_stall", stall_cycles, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
